// File: rtl/sm_sigmoid_pkg.sv
// Shared definitions for the sigmoid LUT lookup controller.
// Holds the state encoding, address width and the enable/clear patterns it drives.
package sm_sigmoid_pkg;

    localparam int ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_LUT_RD = 3'd2,
        ST_CAPT   = 3'd3,
        ST_CLR    = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam logic [2:0] R_SH_NONE    = 3'b000;
    localparam logic [2:0] R_SH_CAPT    = 3'b100;
    localparam logic [1:0] MAC_EN_NONE  = 2'b00;
    localparam logic [1:0] MAC_CLR_NONE = 2'b00;
    localparam logic [1:0] MAC_CLR_ALL  = 2'b11;

endpackage

// File: rtl/sm_sigmoid.sv
// Sequencer for one sigmoid LUT lookup: latches a saturated LUT position,
// steers the datapath onto the LUT, captures the result and clears the MACs.
//
//   state   | meaning
//   IDLE    | waiting for start
//   LATCH   | register saturated lut_idx, LUT selected
//   LUT_RD  | LUT read in flight
//   CAPT    | shift LUT data into the result register
//   CLR     | clear both MAC accumulators
//   DONE    | lookup complete, held until soft reset
module sm_sigmoid
    import sm_sigmoid_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0000,
    parameter int                    LUT_DEPTH   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  reset,
    input  logic [15:0]           lut_idx,
    output logic [15:0]           lut_pos,
    output logic                  lut_sel,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [2:0]            r_sh_en,
    output logic [1:0]            mac_en,
    output logic [1:0]            mac_clr
);

    localparam logic [15:0] POS_MAX = 16'(LUT_DEPTH - 1);

    state_t state;
    state_t state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = ST_LUT_RD;
            ST_LUT_RD: state_nxt = ST_CAPT;
            ST_CAPT:   state_nxt = ST_CLR;
            ST_CLR:    state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // done is registered off the DONE state so it rises one edge after entry,
    // giving a start-to-done latency of five edges.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            lut_pos <= 16'h0000;
            done    <= 1'b0;
        end else begin
            state <= reset ? ST_IDLE : state_nxt;
            done  <= !reset && (state == ST_DONE);
            if (state == ST_LATCH)
                lut_pos <= (lut_idx > POS_MAX) ? POS_MAX : lut_idx;
        end
    end

    assign lut_sel  = (state == ST_LATCH) || (state == ST_LUT_RD) || (state == ST_CAPT);
    assign mem_addr = lut_sel ? ADDR_BASE_A : ADDR_BASE_W;
    assign r_sh_en  = (state == ST_CAPT) ? R_SH_CAPT : R_SH_NONE;
    assign mac_clr  = (state == ST_CLR) ? MAC_CLR_ALL : MAC_CLR_NONE;
    assign mac_en   = MAC_EN_NONE;

endmodule

// File: tb/tb_sm_sigmoid.sv
// Scoreboard bench for sm_sigmoid: random lookups, aborts and ignored starts
// checked against a timeline model of the lookup sequence.
module tb_sm_sigmoid;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] lut_idx = 16'h0000;

    logic [15:0] lut_pos_a, mem_addr_a, lut_pos_b, mem_addr_b;
    logic        lut_sel_a, done_a, lut_sel_b, done_b;
    logic [2:0]  r_sh_en_a, r_sh_en_b;
    logic [1:0]  mac_en_a, mac_clr_a, mac_en_b, mac_clr_b;

    sm_sigmoid dut_a (
        .clk(clk), .rst(rst), .start(start), .reset(reset), .lut_idx(lut_idx),
        .lut_pos(lut_pos_a), .lut_sel(lut_sel_a), .done(done_a), .mem_addr(mem_addr_a),
        .r_sh_en(r_sh_en_a), .mac_en(mac_en_a), .mac_clr(mac_clr_a)
    );

    sm_sigmoid #(.ADDR_BASE_A(16'h1000), .ADDR_BASE_W(16'h2000), .LUT_DEPTH(256)) dut_b (
        .clk(clk), .rst(rst), .start(start), .reset(reset), .lut_idx(lut_idx),
        .lut_pos(lut_pos_b), .lut_sel(lut_sel_b), .done(done_b), .mem_addr(mem_addr_b),
        .r_sh_en(r_sh_en_b), .mac_en(mac_en_b), .mac_clr(mac_clr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    logic [15:0] model_pos = 16'h0000;

    typedef struct {
        int          start_cyc;
        int          abort_a;
        logic [15:0] pos;
        logic [15:0] prev_pos;
    } txn_t;
    txn_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    function automatic logic [15:0] sat_ref(input logic [15:0] idx);
        if (int'(idx) >= DEPTH) return 16'(DEPTH - 1);
        return idx;
    endfunction

    // Monitor: k counts edges since the edge that sampled start.
    // k=0..2 LUT selected, k=2 capture, k=3 MAC clear, done from k=5.
    always @(negedge clk) begin
        int   k;
        bit   ab;
        txn_t t;
        if (mon_en) begin
            k = -1;
            if (exp_q.size() > 0) begin
                t = exp_q[0];
                k = cyc - t.start_cyc;
            end
            if (k >= 0) begin
                ab = (t.abort_a >= 0) && (k >= t.abort_a);
                chk("lut_sel",  lut_sel_a, (!ab && k <= 2));
                chk("r_sh_en",  r_sh_en_a, (!ab && k == 2) ? 3'b100 : 3'b000);
                chk("mac_clr",  mac_clr_a, (!ab && k == 3) ? 2'b11 : 2'b00);
                chk("mac_en",   mac_en_a, 2'b00);
                chk("done",     done_a, (!ab && k >= 5));
                chk("lut_pos",  lut_pos_a, (k >= 1) ? t.pos : t.prev_pos);
                chk("mem_addr_a", mem_addr_a, 16'h0000);
                chk("mem_addr_b", mem_addr_b, (!ab && k <= 2) ? 16'h1000 : 16'h2000);
                if (t.abort_a < 0 && done_a) begin
                    chk("latency", k, 5);
                    void'(exp_q.pop_front());
                end else if (t.abort_a >= 0 && k == t.abort_a + 2) begin
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_mac_en", mac_en_b, 2'b00);
                chk("idle_mem_addr_b", mem_addr_b, 16'h2000);
            end
        end
    end

    task automatic issue(input logic [15:0] idx, input int abort_a);
        txn_t t;
        @(negedge clk);
        start   = 1'b1;
        lut_idx = idx;
        t.start_cyc = cyc + 1;
        t.abort_a   = abort_a;
        t.prev_pos  = model_pos;
        t.pos       = sat_ref(idx);
        model_pos   = t.pos;
        exp_q.push_back(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(input logic [15:0] idx, input int abort_a, input bit poke);
        int w;
        issue(idx, abort_a);
        if (abort_a >= 0) begin
            repeat (abort_a - 1) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            chk("abort_done", done_a, 1'b0);
        end else begin
            if (poke) begin
                @(negedge clk);
                start   = 1'b1;
                lut_idx = 16'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            w = 0;
            while (!done_a && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!done_a) begin
                chk("done_timeout", done_a, 1'b1);
                exp_q.delete();
            end
            start   = 1'b1;
            lut_idx = 16'($urandom);
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("done_held", done_a, 1'b1);
            chk("done_pos_held", lut_pos_a, model_pos);
            chk("done_no_restart", lut_sel_a, 1'b0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            chk("soft_rst_done", done_a, 1'b0);
            chk("soft_rst_sel", lut_sel_a, 1'b0);
            chk("soft_rst_addr_b", mem_addr_b, 16'h2000);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] idx;
        int          ab;
        repeat (2) @(negedge clk);
        chk("rst_lut_pos", lut_pos_a, 16'h0000);
        chk("rst_lut_sel", lut_sel_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_mem_addr_a", mem_addr_a, 16'h0000);
        chk("rst_mem_addr_b", mem_addr_b, 16'h2000);
        chk("rst_r_sh_en", r_sh_en_a, 3'b000);
        chk("rst_mac_en", mac_en_a, 2'b00);
        chk("rst_mac_clr", mac_clr_a, 2'b00);
        rst    = 1'b1;
        mon_en = 1'b1;

        run_txn(16'h0087, -1, 1'b0);
        run_txn(16'h0123, -1, 1'b1);
        run_txn(16'h00FF, -1, 1'b0);
        run_txn(16'h0000, -1, 1'b1);
        run_txn(16'h0100, -1, 1'b0);
        run_txn(16'h00AA, 2, 1'b0);
        run_txn(16'hFFFF, -1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            idx = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 511)) : 16'($urandom);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : -1;
            run_txn(idx, ab, 1'($urandom_range(0, 1)));
        end

        mon_en = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        lut_idx = 16'h0055;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hard_abort_pos", lut_pos_a, 16'h0000);
            chk("hard_abort_sel", lut_sel_a, 1'b0);
            chk("hard_abort_rsh", r_sh_en_a, 3'b000);
            chk("hard_abort_clr", mac_clr_a, 2'b00);
            chk("hard_abort_done", done_a, 1'b0);
            @(negedge clk);
        end
        model_pos = 16'h0000;

        rst   = 1'b0;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        reset = 1'b0;
        chk("rst_over_start_sel", lut_sel_a, 1'b0);
        chk("rst_over_start_addr", mem_addr_b, 16'h2000);
        @(negedge clk);
        chk("rst_over_start_sel2", lut_sel_a, 1'b0);
        mon_en = 1'b1;

        run_txn(16'h0042, -1, 1'b0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
